bit_serial_adder: RTL and testbench

- Multi-bit adder built around a single full-adder cell (a^b^c sum, majority carry) and a registered carry.
- Accepts two WIDTH-bit operands plus carry-in over a valid/ready input handshake.
- Adds them LSB-first, one bit per clock, then returns the WIDTH-bit sum and carry-out over a valid/ready output handshake.
- Acts as the sequencing end of the full-adder interface: it drives a/b/c into the cell each cycle and collects sum/carry, for area-constrained datapaths.

---
 rtl/bit_serial_adder.sv | 115 +++++++++++
 tb/tb_bit_serial_adder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder around a single full-adder cell with a registered carry.
// Operands enter on a valid/ready handshake; {cout,sum} leave on a second handshake.
module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           st_q, st_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // The single full-adder cell, fed from the shifter LSBs and the carry register.
  logic fa_s, fa_c;
  assign fa_s = sha_q[0] ^ shb_q[0] ^ carry_q;
  assign fa_c = (sha_q[0] & shb_q[0]) | (sha_q[0] & carry_q) | (shb_q[0] & carry_q);

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the first one computed.
  logic [WIDTH-1:0] s_msb, res_shift;
  always_comb begin
    s_msb            = '0;
    s_msb[WIDTH-1]   = fa_s;
    res_shift        = (res_q >> 1) | s_msb;
  end

  always_comb begin
    st_d    = st_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (st_q)
      StIdle: begin
        if (in_valid) begin
          sha_d   = op_a;
          shb_d   = op_b;
          carry_d = cin;
          cnt_d   = '0;
          st_d    = StRun;
        end
      end
      StRun: begin
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        carry_d = fa_c;
        res_d   = res_shift;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          sum_d  = res_shift;
          cout_d = fa_c;
          cnt_d  = cnt_q;
          st_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      sha_q   <= '0;
      shb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // in_ready is gated by rst_n directly so it drops the instant reset asserts.
  assign in_ready  = rst_n && (st_q == StIdle);
  assign out_valid = (st_q == StDone);
  assign busy      = (st_q != StIdle);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random checks of bit_serial_adder at WIDTH=8: arithmetic, latency,
// backpressure, asynchronous reset mid-operation and handshake exclusivity.
module tb_bit_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_total = 0;
  int n_pass  = 0;
  int viol    = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && in_ready && busy) viol++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Presents operands, waits for the result, then holds out_ready low for `stall` cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int stall, output logic [W:0] res, output int lat);
    int guard = 0;
    out_ready = (stall == 0);
    op_a = a; op_b = b; cin = c; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 50);
    res = {cout, sum};
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [W:0] res;
    int lat, guard, stale;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};

    #12;
    check("rst in_ready",  32'(in_ready), 0);
    check("rst out_valid", 32'(out_valid), 0);
    check("rst busy",      32'(busy), 0);
    check("rst sum",       32'(sum), 0);
    check("rst cout",      32'(cout), 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("post-rst in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, 0, res, lat);
      check($sformatf("vec%0d sum", i),  32'(res[W-1:0]), 32'(vecs[i].s));
      check($sformatf("vec%0d cout", i), 32'(res[W]), 32'(vecs[i].co));
      check($sformatf("vec%0d latency", i), lat, W);
    end

    // Backpressure: result 0x46 must stay frozen while new operands wait.
    out_ready = 1'b0;
    op_a = 8'h12; op_b = 8'h34; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    op_a = 8'h11; op_b = 8'h22; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d sum", k), 32'(sum), 32'h46);
      check($sformatf("stall%0d out_valid", k), 32'(out_valid), 1);
      check($sformatf("stall%0d in_ready", k), 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release out_valid", 32'(out_valid), 0);
    check("release in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("queued accepted busy", 32'(busy), 1);
    guard = 0;
    while (!out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    check("queued sum", 32'(sum), 32'h33);
    check("queued cout", 32'(cout), 0);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset in the middle of RUN.
    out_ready = 1'b1;
    op_a = 8'h0F; op_b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid), 0);
    check("midrst busy",      32'(busy), 0);
    check("midrst sum",       32'(sum), 0);
    check("midrst cout",      32'(cout), 0);
    check("midrst in_ready",  32'(in_ready), 0);
    @(negedge clk) rst_n = 1'b1;
    stale = 0;
    repeat (12) begin @(negedge clk); if (out_valid) stale++; end
    check("no stale valid", stale, 0);
    run_op(8'h01, 8'h01, 1'b0, 0, res, lat);
    check("after rst result", 32'(res), 32'h002);

    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] a, b;
      logic c;
      logic [W:0] exp;
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      run_op(a, b, c, $urandom_range(0, 3), res, lat);
      check($sformatf("rand%0d %0h+%0h+%0d", i, a, b, c), 32'(res), 32'(exp));
    end

    check("in_ready while busy", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
